// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift serializer.
package shift_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1 and wraps.
module shift_bit_counter #(
  parameter  int WIDTH = 16,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] count;

  assign tc = (count == CW'(WIDTH - 1));

  // Explicit wrap keeps non-power-of-two widths correct.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/shift_serializer.sv
// Word-to-bit serializer driving a downstream left/right shifter, with a
// one-word pending slot so consecutive words stream without a gap.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             load,
  output logic             d,
  output logic             direction,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] act_word, pend_word;
  logic             act_dir, pend_dir, pend_valid;
  logic             tc, hs;
  logic             take_in, take_pend, store_pend;
  logic             shifting;

  assign shifting  = (state_q == SHIFT);
  assign in_ready  = ~pend_valid & ~reset;
  assign hs        = in_valid & in_ready;
  assign load      = shifting;
  assign direction = act_dir;
  assign d         = shifting ? (act_dir ? act_word[0] : act_word[WIDTH-1]) : 1'b0;

  shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (~shifting),
    .enable (shifting),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    take_in    = 1'b0;
    take_pend  = 1'b0;
    store_pend = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SHIFT;
          take_in = 1'b1;
        end
      end
      SHIFT: begin
        if (tc) begin
          // Final bit: refill from pending first, else bypass a fresh word.
          if (pend_valid)  take_pend = 1'b1;
          else if (hs)     take_in   = 1'b1;
          else             state_d   = IDLE;
        end else if (hs) begin
          store_pend = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_word   <= '0;
      act_dir    <= 1'b0;
      pend_word  <= '0;
      pend_dir   <= 1'b0;
      pend_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= shifting & tc;
      if (take_pend) begin
        act_word <= pend_word;
        act_dir  <= pend_dir;
      end else if (take_in) begin
        act_word <= in_data;
        act_dir  <= in_dir;
      end else if (shifting) begin
        act_word <= act_dir ? (act_word >> 1) : (act_word << 1);
      end
      if (store_pend) begin
        pend_word  <= in_data;
        pend_dir   <= in_dir;
        pend_valid <= 1'b1;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: queue-of-words reference model plus a
// behavioural downstream shifter, directed scenarios then random traffic.
module tb_shift_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         load, d, direction, done;

  shift_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .load      (load),
    .d         (d),
    .direction (direction),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] w;
    logic         dir;
  } word_t;

  word_t        q[$];
  int           bitpos;
  logic         exp_done;
  logic         last_dir;
  logic [W-1:0] last_word;
  logic [W-1:0] shf;
  logic [W-1:0] cap;
  int           ld_cnt, done_cnt;
  int           checks = 0;
  int           failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    bitpos   = 0;
    exp_done = 1'b0;
    last_dir = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check against model, advance at posedge.
  task automatic cyc(input logic v, input logic [W-1:0] data, input logic dir);
    logic exp_ready, exp_d, hs, ld_s, d_s, dir_s;
    word_t nw;
    @(negedge clk);
    in_valid = v;
    in_data  = data;
    in_dir   = dir;
    #1;
    exp_ready = (q.size() < 2);
    chk("in_ready", in_ready, exp_ready);
    chk("load", load, q.size() > 0);
    if (q.size() > 0) begin
      exp_d = q[0].dir ? q[0].w[bitpos] : q[0].w[W-1-bitpos];
      chk("d", d, exp_d);
      chk("direction", direction, q[0].dir);
      last_dir = q[0].dir;
    end else begin
      chk("d_idle", d, 1'b0);
      chk("direction_idle", direction, last_dir);
    end
    chk("done", done, exp_done);
    if (exp_done) chk("shifter_out", shf, last_word);
    ld_s  = load;
    d_s   = d;
    dir_s = direction;
    hs    = v && exp_ready;
    @(posedge clk);
    if (ld_s) begin
      shf = dir_s ? {d_s, shf[W-1:1]} : {shf[W-2:0], d_s};
      cap = {cap[W-2:0], d_s};
      ld_cnt++;
    end
    if (exp_done) done_cnt++;
    exp_done = 1'b0;
    if (q.size() > 0) begin
      bitpos++;
      if (bitpos == W) begin
        last_word = q[0].w;
        void'(q.pop_front());
        bitpos   = 0;
        exp_done = 1'b1;
      end
    end
    if (hs) begin
      nw.w   = data;
      nw.dir = dir;
      q.push_back(nw);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst_load", load, 1'b0);
    chk("rst_d", d, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_direction", direction, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dir   = 1'b0;
    shf      = '0;
    cap      = '0;
    last_word = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_load", load, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // MSB-first word from idle
    cap = '0;
    cyc(1'b1, 16'hA5C3, 1'b0);
    idle(18);
    chk("a5c3_bits", cap, 16'hA5C3);

    // LSB-first word, shifter must rebuild it
    cyc(1'b1, 16'h0001, 1'b1);
    idle(18);
    chk("lsb_shifter", shf, 16'h0001);

    // back-to-back via pending slot
    ld_cnt = 0; done_cnt = 0; cap = '0;
    cyc(1'b1, 16'hFFFF, 1'b0);
    idle(2);
    cyc(1'b1, 16'h0000, 1'b0);
    idle(35);
    chk("b2b_loads", ld_cnt, 32);
    chk("b2b_dones", done_cnt, 2);
    chk("b2b_last_bits", cap, 16'h0000);

    // bypass on final bit cycle
    cap = '0;
    cyc(1'b1, 16'h1234, 1'b0);
    idle(15);
    cyc(1'b1, 16'h8000, 1'b0);
    idle(18);
    chk("bypass_bits", cap, 16'h8000);

    // reset mid-word with a pending word
    cyc(1'b1, 16'hFFFF, 1'b0);
    cyc(1'b1, 16'hAAAA, 1'b1);
    idle(4);
    do_reset();
    cap = '0; done_cnt = 0;
    cyc(1'b1, 16'h0F0F, 1'b0);
    idle(18);
    chk("post_reset_bits", cap, 16'h0F0F);
    chk("post_reset_dones", done_cnt, 1);

    // random traffic
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 2) != 0, W'($urandom), 1'($urandom));
    do_reset();
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 3) == 0, W'($urandom), 1'($urandom));
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, word length in bits; equals width of downstream shifter's parallel out.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream word available.
REQ-005 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  word to serialize.
REQ-007 SHALL have port: in_dir  input  1  0 = left shift (MSB first), 1 = right shift (LSB first).
REQ-008 SHALL have port: load  output  1  shift-enable to downstream lrshifter; high exactly on bit cycles.
REQ-009 SHALL have port: d  output  1  serial data bit to downstream shifter.
REQ-010 SHALL have port: direction  output  1  shift direction to downstream shifter.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT; handshake = in_valid & in_ready on a rising edge.
REQ-013 SHALL hold one active word (shift register + dir) and one pending slot (word + dir + valid flag).
REQ-014 SHALL drive in_ready = 1 when pending slot empty and reset deasserted; 0 otherwise.
REQ-015 IDLE: handshake loads active word directly; next state SHIFT.
REQ-016 SHIFT: load = 1, direction = active dir, d = active MSB (dir 0) or LSB (dir 1); active word shifts one bit per cycle.
REQ-017 SHALL count bit cycles with a $clog2(WIDTH)-bit counter, 0..WIDTH-1, wrapping to 0 after WIDTH-1.
REQ-018 SHIFT, non-final cycle: handshake stores word into pending slot.
REQ-019 Final bit cycle: pending valid -> pending moves to active, stays SHIFT with no gap; else handshake this cycle -> in_data bypasses to active, stays SHIFT; else -> IDLE.
REQ-020 done SHALL be registered, high exactly one cycle, the cycle after each final bit cycle (coincides with next word's first bit when back-to-back).
REQ-021 Latency: word accepted in IDLE at edge N -> first bit at cycle N+1, last at N+WIDTH, done at N+WIDTH+1.
REQ-022 IDLE outputs: load = 0, d = 0, direction holds last driven value.
REQ-023 Words SHALL never be dropped or reordered; at most two words in flight (active + pending).

Reset
REQ-024 reset assertion SHALL immediately force state IDLE, load = 0, d = 0, direction = 0, done = 0, counter = 0, pending valid = 0, in_ready = 0.
REQ-025 Reset mid-word SHALL discard active and pending words with no done pulse; in_ready = 1 first cycle after release.

Structure
REQ-026 Package shift_pkg SHALL hold the FSM state typedef and default WIDTH constant.
REQ-027 Bit counter SHALL be one sub-module, shift_bit_counter (clear, enable, terminal-count output); all else inline.

Verification
REQ-028 IDLE, accept 16'hA5C3 dir 0 -> d = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over 16 load-high cycles, direction = 0, done at cycle 17.
REQ-029 Accept 16'h0001 dir 1 -> d = 1 then fifteen 0s, direction = 1; attached lrshifter out equals 16'h0001 after done.
REQ-030 Accept 16'hFFFF, then 16'h0000 at bit 3 -> in_ready low bits 4-16, 32 contiguous load cycles, d = 16x1 then 16x0, done after bit 16 and bit 32.
REQ-031 in_valid with 16'h8000 dir 0 on final bit cycle of 16'h1234, pending empty -> bypass, no gap, next d = 1 then fifteen 0s.
REQ-032 Assert reset after 5 bits of 16'hFFFF with word pending -> load = 0, d = 0 immediately, no done; after release in_ready = 1, next word from bit 0.
